mul4_share_arbiter: RTL and testbench
=====================================

# mul4_share_arbiter

Round-robin arbiter and sequencer that shares one combinational 4x4 unsigned multiplier among NREQ requesters. Requesters present operand pairs on a valid/ready handshake. The block grants one request at a time, drives the shared multiplier's operand inputs from registers, captures its 8-bit product, and returns the product with the requester ID on a valid/ready response channel. It sits between the requesting datapath clients and the single multiplier instance.

## Interface
- NREQ, 4, number of requesters, legal range 2..8
- IDW, derived as clog2(NREQ) (2 at default), width of the requester ID; local, not overridable

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_a  in  4*NREQ  operand A, requester i at bits [4i+3:4i]
- req_b  in  4*NREQ  operand B, same packing as req_a
- req_ready  out  NREQ  one-hot grant/accept, at most one bit high
- mul_a  out  4  operand A to the shared multiplier
- mul_b  out  4  operand B to the shared multiplier
- mul_p  in  8  product from the shared multiplier (combinational, mul_a*mul_b)
- rsp_valid  out  1  response valid
- rsp_p  out  8  captured product
- rsp_id  out  IDW  index of the requester that owns rsp_p
- rsp_ready  in  1  response consumer ready

## Operation
- FSM states: IDLE, MUL, RESP. Reset state is IDLE.
- IDLE:
  - The grant index g is the first set bit of req_valid, searching from ptr upward and wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in this same cycle. That cycle is the acceptance.
  - On acceptance: op_a<=req_a[g], op_b<=req_b[g], op_id<=g, ptr<=(g+1) mod NREQ, state<=MUL.
  - If no req_valid bit is set: req_ready=0 and the block stays in IDLE.
- MUL:
  - mul_a=op_a and mul_b=op_b (register outputs).
  - At the clock edge: rsp_p<=mul_p, rsp_id<=op_id, rsp_valid<=1, state<=RESP.
- RESP:
  - rsp_valid, rsp_p and rsp_id are held stable.
  - When rsp_ready=1: rsp_valid<=0 and state<=IDLE. Otherwise the block stays in RESP indefinitely.
- req_ready is 0 in MUL and RESP. Requests arriving then wait.
- A requester may drop req_valid before acceptance. Arbitration is re-evaluated every IDLE cycle.
- A requester must hold req_a/req_b stable while req_valid=1.
- Arithmetic: operands are unsigned. The product is 0..225 and fits in 8 bits. The block never alters mul_p.
- mul_a/mul_b keep their last values outside MUL.

## Timing
- Reset values: req_ready=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_p=0, rsp_id=0, ptr=0, state=IDLE.
- Acceptance in cycle T → mul_a/mul_b valid in T+1 → rsp_valid=1 from T+2.
- Minimum initiation interval is 3 cycles: with rsp_ready held at 1, the next acceptance is at T+3.
- rsp_ready is sampled only in RESP. A rsp_ready of 1 during IDLE or MUL has no effect.
- Simultaneous requests: exactly one is granted per acceptance. ptr advances past the winner, so every continuously requesting requester is served within NREQ operations.
- Reset asserted mid-operation clears everything immediately and asynchronously. The in-flight operation and its response are discarded and are not replayed.
- Single-requester case: the grant goes to that requester regardless of ptr.

## Configuration
- MUL4ARB_FIXED_PRIO_EN defined: ptr is ignored and stays 0. The grant is always the lowest-index set bit of req_valid (strict priority, requester 0 highest).
- Not defined: round-robin as described above.
- Latency and handshakes are identical in both modes.

## Test plan
- Reset then a single request on requester 2 with a=3, b=5 → req_ready=4'b0100 at acceptance, rsp_valid at T+2 with rsp_p=15 and rsp_id=2.
- Requester 0 with a=15, b=15 → rsp_p=225. With a=0, b=9 → rsp_p=0.
- All four requesters held valid, rsp_ready=1 → grant order 0,1,2,3,0, with acceptances exactly 3 cycles apart.
- rsp_ready=0 for 5 cycles after rsp_valid rises → rsp_p, rsp_id and rsp_valid stay stable, req_ready stays 0, and the next grant comes 1 cycle after the rsp_ready handshake.
- rst_n pulsed low during MUL → all outputs go to reset values immediately, no response is issued, and ptr=0 afterwards.
- With MUL4ARB_FIXED_PRIO_EN, requesters 1 and 3 held valid → requester 1 is granted every time and requester 3 is never granted.

Source files
------------

// File: rtl/mul4_share_arbiter_if.sv
// mul4_share_arbiter_if: request, shared-multiplier and response signals of mul4_share_arbiter
//   req_valid/req_ready/req_a/req_b : per-requester operand handshake (4-bit lanes)
//   mul_a/mul_b/mul_p               : operands to and product from the shared multiplier
//   rsp_valid/rsp_ready/rsp_p/rsp_id: product response with owning requester id
//   slave modport = arbiter side, master modport = requesters/multiplier/consumer side
interface mul4_share_arbiter_if #(parameter int NREQ = 4);
  localparam int IDW = $clog2(NREQ);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic [7:0] mul_p;
  logic rsp_valid;
  logic rsp_ready;
  logic [7:0] rsp_p;
  logic [IDW-1:0] rsp_id;
  modport slave (
    input req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_p, rsp_id
  );
  modport master (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input req_ready, mul_a, mul_b, rsp_valid, rsp_p, rsp_id
  );
endinterface

// File: rtl/mul4_share_arbiter.sv
// mul4_share_arbiter: round-robin sharing of one combinational 4x4 multiplier among NREQ requesters
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mul4_share_arbiter_if.slave (request handshake, multiplier operands/product, response)
//   Define MUL4ARB_FIXED_PRIO_EN for strict priority (requester 0 highest) instead of round-robin.
module mul4_share_arbiter #(
  parameter int NREQ = 4
) (
  input logic clk,
  input logic rst_n,
  mul4_share_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
  state_t state, state_n;
  logic [IDW-1:0] ptr, g, g_next, op_id, rsp_id, j;
  logic [IDW:0] sum;
  logic [3:0] op_a, op_b;
  logic [7:0] rsp_p;
  logic rsp_valid, accept;
  // Scan from ptr downward-in-priority so the last hit is the first set bit at or after ptr.
  always_comb begin
    g = '0;
    sum = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDW + 1)'(k);
      j = IDW'(sum >= (IDW + 1)'(NREQ) ? sum - (IDW + 1)'(NREQ) : sum);
      if (bus.req_valid[j]) g = j;
    end
  end
`ifdef MUL4ARB_FIXED_PRIO_EN
  assign g_next = '0;
`else
  assign g_next = (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
`endif
  // Gated by rst_n so no grant is shown while reset is held.
  assign accept = rst_n && state == IDLE && |bus.req_valid;
  assign bus.req_ready = accept ? {{(NREQ - 1){1'b0}}, 1'b1} << g : '0;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (accept ? MUL : IDLE) :
              (state == MUL) ? RESP :
              (bus.rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      op_a <= '0;
      op_b <= '0;
      op_id <= '0;
      rsp_p <= '0;
      rsp_id <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_a <= bus.req_a[4*g +: 4];
        op_b <= bus.req_b[4*g +: 4];
        op_id <= g;
        ptr <= g_next;
      end
      if (state == MUL) begin
        rsp_p <= bus.mul_p;
        rsp_id <= op_id;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && bus.rsp_ready) rsp_valid <= 1'b0;
    end
  end
  assign bus.mul_a = op_a;
  assign bus.mul_b = op_b;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_p = rsp_p;
  assign bus.rsp_id = rsp_id;
endmodule

// File: tb/tb_mul4_share_arbiter.sv
// tb_mul4_share_arbiter: directed self-checking bench for mul4_share_arbiter (NREQ=4)
module tb_mul4_share_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  mul4_share_arbiter_if #(.NREQ(4)) bus();
  assign bus.mul_p = bus.mul_a * bus.mul_b;
  mul4_share_arbiter #(.NREQ(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_reset;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    #2;
    checks++; if (bus.req_ready !== 4'b0) $display("FAIL reset_req_ready: got %b exp 0000", bus.req_ready); else passed++;
    checks++; if (bus.mul_a !== 4'd0) $display("FAIL reset_mul_a: got %0d exp 0", bus.mul_a); else passed++;
    checks++; if (bus.mul_b !== 4'd0) $display("FAIL reset_mul_b: got %0d exp 0", bus.mul_b); else passed++;
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b exp 0", bus.rsp_valid); else passed++;
    checks++; if (bus.rsp_p !== 8'd0) $display("FAIL reset_rsp_p: got %0d exp 0", bus.rsp_p); else passed++;
    checks++; if (bus.rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d exp 0", bus.rsp_id); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_products;
    int vid[3] = '{2, 0, 0};
    int va[3] = '{3, 15, 0};
    int vb[3] = '{5, 15, 9};
    int vp[3] = '{15, 225, 0};
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 4'(1 << vid[i]);
      bus.req_a = 16'(va[i] << (4 * vid[i]));
      bus.req_b = 16'(vb[i] << (4 * vid[i]));
      #1;
      checks++; if (bus.req_ready !== 4'(1 << vid[i])) $display("FAIL prod%0d_grant: got %b exp %b", i, bus.req_ready, 4'(1 << vid[i])); else passed++;
      tick;
      bus.req_valid = '0;
      #1;
      checks++; if ({bus.req_ready, bus.rsp_valid, bus.mul_a, bus.mul_b} !== {4'b0, 1'b0, 4'(va[i]), 4'(vb[i])}) $display("FAIL prod%0d_mul: ready=%b valid=%b a=%0d b=%0d exp 0000 0 %0d %0d", i, bus.req_ready, bus.rsp_valid, bus.mul_a, bus.mul_b, va[i], vb[i]); else passed++;
      tick;
      #1;
      checks++; if ({bus.rsp_valid, bus.rsp_p, bus.rsp_id} !== {1'b1, 8'(vp[i]), 2'(vid[i])}) $display("FAIL prod%0d_rsp: valid=%b p=%0d id=%0d exp 1 %0d %0d", i, bus.rsp_valid, bus.rsp_p, bus.rsp_id, vp[i], vid[i]); else passed++;
      tick;
      #1;
      checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL prod%0d_release: rsp_valid=%b exp 0", i, bus.rsp_valid); else passed++;
      tick;
    end
  endtask
  task automatic test_round_robin;
    int gi[5];
    int gc[5];
    int n = 0;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    do_reset;
    bus.rsp_ready = 1'b1;
    bus.req_a = 16'h4321;
    bus.req_b = 16'h2345;
    bus.req_valid = 4'hf;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.req_ready !== 4'b0 && n < 5) begin
        for (int b = 0; b < 4; b++) if (bus.req_ready[b]) gi[n] = b;
        gc[n] = c;
        n++;
      end
      tick;
    end
    bus.req_valid = '0;
    checks++; if (n !== 5) $display("FAIL rr_count: got %0d grants exp 5", n); else passed++;
    for (int i = 0; i < n; i++) begin
      checks++; if (gi[i] !== exp_g[i]) $display("FAIL rr_order%0d: got %0d exp %0d", i, gi[i], exp_g[i]); else passed++;
    end
    for (int i = 1; i < n; i++) begin
      checks++; if (gc[i] - gc[i-1] !== 3) $display("FAIL rr_spacing%0d: got %0d exp 3", i, gc[i] - gc[i-1]); else passed++;
    end
    repeat (4) tick;
  endtask
  task automatic test_fixed_prio;
    int cnt1 = 0;
    int cnt3 = 0;
    do_reset;
    bus.rsp_ready = 1'b1;
    bus.req_a = 16'h5040;
    bus.req_b = 16'h3020;
    bus.req_valid = 4'b1010;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (bus.req_ready[1]) cnt1++;
      if (bus.req_ready[3]) cnt3++;
      tick;
    end
    bus.req_valid = '0;
    checks++; if (cnt1 !== 5) $display("FAIL fixed_req1: got %0d grants exp 5", cnt1); else passed++;
    checks++; if (cnt3 !== 0) $display("FAIL fixed_req3: got %0d grants exp 0", cnt3); else passed++;
    repeat (4) tick;
  endtask
  task automatic test_backpressure;
    do_reset;
    bus.req_a = 16'h0060;
    bus.req_b = 16'h0070;
    bus.req_valid = 4'b0110;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) $display("FAIL bp_grant: got %b exp 0010", bus.req_ready); else passed++;
    tick;
    #1;
    checks++; if (bus.req_ready !== 4'b0) $display("FAIL bp_mul_ready: got %b exp 0000", bus.req_ready); else passed++;
    tick;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if ({bus.rsp_valid, bus.rsp_p, bus.rsp_id, bus.req_ready} !== {1'b1, 8'd42, 2'd1, 4'b0}) $display("FAIL bp_hold%0d: valid=%b p=%0d id=%0d ready=%b exp 1 42 1 0000", k, bus.rsp_valid, bus.rsp_p, bus.rsp_id, bus.req_ready); else passed++;
      tick;
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if ({bus.rsp_valid, bus.req_ready} !== {1'b1, 4'b0}) $display("FAIL bp_handshake: valid=%b ready=%b exp 1 0000", bus.rsp_valid, bus.req_ready); else passed++;
    tick;
    #1;
    checks++; if ({bus.rsp_valid, bus.req_ready} !== {1'b0, 4'b0100}) $display("FAIL bp_next_grant: valid=%b ready=%b exp 0 0100", bus.rsp_valid, bus.req_ready); else passed++;
    bus.req_valid = '0;
    tick;
  endtask
  task automatic test_reset_mid;
    int leaked = 0;
    do_reset;
    bus.rsp_ready = 1'b1;
    bus.req_a = 16'h0020;
    bus.req_b = 16'h0020;
    bus.req_valid = 4'b0010;
    tick;
    bus.req_valid = '0;
    #1;
    checks++; if ({bus.mul_a, bus.mul_b} !== {4'd2, 4'd2}) $display("FAIL mid_mul_ops: a=%0d b=%0d exp 2 2", bus.mul_a, bus.mul_b); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.req_ready, bus.mul_a, bus.mul_b, bus.rsp_valid, bus.rsp_p, bus.rsp_id} !== 27'd0) $display("FAIL mid_reset_clear: ready=%b a=%0d b=%0d valid=%b p=%0d id=%0d exp all 0", bus.req_ready, bus.mul_a, bus.mul_b, bus.rsp_valid, bus.rsp_p, bus.rsp_id); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (bus.rsp_valid !== 1'b0) leaked++;
    end
    checks++; if (leaked !== 0) $display("FAIL mid_no_response: rsp_valid high %0d cycles exp 0", leaked); else passed++;
    bus.req_valid = 4'b0110;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) $display("FAIL mid_ptr_cleared: got %b exp 0010", bus.req_ready); else passed++;
    bus.req_valid = '0;
    tick;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_products;
`ifdef MUL4ARB_FIXED_PRIO_EN
    test_fixed_prio;
`else
    test_round_robin;
`endif
    test_backpressure;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
